fetch_ctrl: RTL
===============

// Module: fetch_ctrl
// PURPOSE
//  Instruction-fetch sequencer for the 128x9 instruction ROM.
//  - Owns the program counter and drives the ROM address (ROM read is combinational).
//  - Registers the returned word into an instruction register for the decoder.
//  - Applies stall, branch/jump redirect and halt, and reports run completion.
//  - Sits between the instruction ROM and decode/control.
// PARAMETERS
//  PC_W        7    program-counter / ROM address width
//  INST_W      9    instruction width
//  START_ADDR  0    PC loaded on Start
//  CNT_W       16   retired-instruction counter width
// PORTS
//  CLK          in   1       clock, rising edge
//  Reset        in   1       synchronous, active-high
//  Start        in   1       begin a run (honoured in IDLE or HALTED only)
//  Stall        in   1       hold PC, Inst, InstValid and counter
//  Halt         in   1       decoder flags Inst as halt (qualified by InstValid)
//  BranchEn     in   1       redirect fetch (qualified by InstValid)
//  BranchAbs    in   1       1: target = BranchTarget; 0: PC-relative
//  BranchTarget in   PC_W    absolute address, or signed offset from InstPC
//  InstIn       in   INST_W  ROM data for InstAddress
//  InstAddress  out  PC_W    ROM address (= PC register)
//  Inst         out  INST_W  instruction register
//  InstPC       out  PC_W    address Inst was fetched from
//  InstValid    out  1       Inst holds a live instruction
//  Done         out  1       run finished; held until next Start
//  InstCount    out  CNT_W   retired instructions this run, saturating
// BEHAVIOUR
//  Reset values
//   - State = IDLE.
//   - PC = START_ADDR.
//   - Inst, InstPC, InstCount = 0.
//   - InstValid = 0, Done = 0.
//   - Reset mid-run aborts the run immediately; no partial state survives.
//  State machine: IDLE, RUN, HALTED.
//   - IDLE --Start--> RUN.
//   - RUN --Halt&InstValid--> HALTED.
//   - HALTED --Start--> RUN.
//   - Start in RUN is ignored.
//  Entering RUN
//   - PC = START_ADDR, InstValid = 0, InstCount = 0, Done = 0.
//   - First instruction is valid 2 cycles after the Start edge.
//  RUN, per cycle, priority Halt > Stall > BranchEn > sequential:
//   - Halt (InstValid=1):
//     - Next state HALTED; InstValid = 0; Done = 1.
//     - InstCount increments (the halt instruction retires).
//   - Stall:
//     - All registers hold; InstCount does not increment.
//   - BranchEn (InstValid=1):
//     - Word fetched this cycle is squashed: InstValid = 0.
//     - PC = BranchAbs ? BranchTarget : InstPC + sext(BranchTarget).
//     - InstCount increments.
//   - Sequential:
//     - Inst = InstIn, InstPC = PC, PC = PC+1, InstValid = 1.
//     - InstCount increments if the previous InstValid = 1.
//   - Halt/BranchEn while InstValid = 0 are ignored.
//  Branch timing: net 1-cycle bubble; no delay slot.
//  Arithmetic
//   - PC add is modulo 2^PC_W: 127+1 -> 0; relative targets wrap silently.
//   - InstCount saturates at all-ones.
//  HALTED: PC, Inst, InstPC, InstCount frozen; Done stays 1.
//  IDLE: InstValid = 0, Done = 0; inputs other than Start ignored.
// STRUCTURE
//  - fetch_pkg: state enum fetch_state_t {IDLE, RUN, HALTED}; widths PC_W/INST_W.
//  - Single module, no sub-module: PC next-state mux, IR, FSM, counter.
//  - All registers in one always_ff on CLK with synchronous Reset.
// TESTING
//  1. ROM[0..3] = 001,002,003,1FF; Halt decoded on 1FF:
//     -> Inst sequence 001,002,003,1FF; Done=1; InstCount=4; PC frozen at 4.
//  2. Stall high 3 cycles while Inst=002:
//     -> Inst, PC, InstCount unchanged 3 cycles; resumes with 003.
//  3. BranchEn, BranchAbs=0, BranchTarget=7'h7E (-2), at InstPC=5:
//     -> one invalid cycle, next valid Inst from address 3.
//  4. BranchAbs=1, BranchTarget=127, then run sequentially:
//     -> addresses 127, 0, 1 fetched (wrap).
//  5. Reset asserted mid-run at PC=10:
//     -> next cycle IDLE, PC=0, InstValid=0, Done=0.
//     Start in RUN is ignored.
//     Start after Done -> restart at address 0, InstCount cleared.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and default widths for the instruction-fetch sequencer.
// Holds the fetch FSM state encoding used by fetch_ctrl.
package fetch_pkg;

   localparam int PC_W   = 7;
   localparam int INST_W = 9;
   localparam int CNT_W  = 16;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      HALTED
   } fetch_state_t;

endpackage

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer for the 128x9 instruction ROM: owns the PC,
// registers the ROM word into an IR, applies stall/branch/halt and counts retirement.
// Ports:
//   CLK, Reset           clock (rising edge), synchronous active-high reset
//   Start                begin a run (IDLE or HALTED only)
//   Stall                hold PC, Inst, InstValid and counter
//   Halt                 decoder flags Inst as halt (qualified by InstValid)
//   BranchEn/BranchAbs   redirect fetch, absolute or InstPC-relative
//   BranchTarget         absolute address or signed offset
//   InstIn               combinational ROM data for InstAddress
//   InstAddress          ROM address (PC register)
//   Inst, InstPC         instruction register and its fetch address
//   InstValid            Inst holds a live instruction
//   Done                 run finished, held until next Start
//   InstCount            retired instructions this run, saturating
module fetch_ctrl
   import fetch_pkg::*;
#(
   parameter int                 P_PC_W     = PC_W,
   parameter int                 P_INST_W   = INST_W,
   parameter logic [P_PC_W-1:0]  START_ADDR = '0,
   parameter int                 P_CNT_W    = CNT_W
) (
   input  logic                  CLK,
   input  logic                  Reset,
   input  logic                  Start,
   input  logic                  Stall,
   input  logic                  Halt,
   input  logic                  BranchEn,
   input  logic                  BranchAbs,
   input  logic [P_PC_W-1:0]     BranchTarget,
   input  logic [P_INST_W-1:0]   InstIn,
   output logic [P_PC_W-1:0]     InstAddress,
   output logic [P_INST_W-1:0]   Inst,
   output logic [P_PC_W-1:0]     InstPC,
   output logic                  InstValid,
   output logic                  Done,
   output logic [P_CNT_W-1:0]    InstCount
);

   fetch_state_t          state_q, state_d;
   logic [P_PC_W-1:0]     pc_q, pc_d;
   logic [P_INST_W-1:0]   inst_q, inst_d;
   logic [P_PC_W-1:0]     ipc_q, ipc_d;
   logic                  valid_q, valid_d;
   logic                  done_q, done_d;
   logic [P_CNT_W-1:0]    cnt_q, cnt_d;

   logic [P_CNT_W-1:0]    cnt_inc;
   logic [P_PC_W-1:0]     br_tgt;

   // Saturate rather than wrap so long runs never report a small count.
   assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + P_CNT_W'(1);

   // Offset has the PC width, so sign extension is the identity and the
   // add wraps modulo 2^PC_W.
   assign br_tgt = BranchAbs ? BranchTarget : ipc_q + BranchTarget;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      inst_d  = inst_q;
      ipc_d   = ipc_q;
      valid_d = valid_q;
      done_d  = done_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE, HALTED: begin
            if (state_q == IDLE) begin
               valid_d = 1'b0;
               done_d  = 1'b0;
            end
            if (Start) begin
               state_d = RUN;
               pc_d    = START_ADDR;
               valid_d = 1'b0;
               cnt_d   = '0;
               done_d  = 1'b0;
            end
         end
         RUN: begin
            if (Halt && valid_q) begin
               state_d = HALTED;
               valid_d = 1'b0;
               done_d  = 1'b1;
               cnt_d   = cnt_inc;
            end else if (Stall) begin
               // everything holds
            end else if (BranchEn && valid_q) begin
               // The word on InstIn is the wrong path; drop it.
               valid_d = 1'b0;
               pc_d    = br_tgt;
               cnt_d   = cnt_inc;
            end else begin
               inst_d  = InstIn;
               ipc_d   = pc_q;
               pc_d    = pc_q + P_PC_W'(1);
               valid_d = 1'b1;
               if (valid_q) cnt_d = cnt_inc;
            end
         end
         default: begin
            state_d = IDLE;
            valid_d = 1'b0;
            done_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (Reset) begin
         state_q <= IDLE;
         pc_q    <= START_ADDR;
         inst_q  <= '0;
         ipc_q   <= '0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         inst_q  <= inst_d;
         ipc_q   <= ipc_d;
         valid_q <= valid_d;
         done_q  <= done_d;
         cnt_q   <= cnt_d;
      end
   end

   assign InstAddress = pc_q;
   assign Inst        = inst_q;
   assign InstPC      = ipc_q;
   assign InstValid   = valid_q;
   assign Done        = done_q;
   assign InstCount   = cnt_q;

endmodule
